// File: rtl/even_parity_pkg.sv
// Shared types and helpers for the even-parity serializer and its checker-side model.
package even_parity_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Even parity bit: makes the total count of ones (data plus parity) even.
    function automatic logic even_par(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/parity_shift_reg.sv
// Load/shift register for one frame: holds the word being serialized, its
// latched parity bit and the count of data bits already shifted out.
module parity_shift_reg
    import even_parity_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    input  logic              par_in,
    output logic              bit_out,
    output logic              par,
    output logic              last
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;

    assign bit_out = sreg[0];
    assign last    = (cnt == CNT_W'(DATA_W - 1));

    // Load has priority; the counter saturates on the last data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
            par  <= 1'b0;
        end else if (load) begin
            sreg <= data;
            cnt  <= '0;
            par  <= par_in;
        end else if (shift) begin
            sreg <= sreg >> 1;
            if (!last) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/even_parity_serializer.sv
// Even-parity serializer: takes a word over valid/ready and emits it LSB first,
// followed by its even-parity bit. Frames can run back to back because a new
// word is accepted during the parity cycle of the previous one.
// Optional build macro PARITY_ERR_INJECT_EN adds err_inject, which inverts the
// parity of the frame accepted with it.
module even_parity_serializer
    import even_parity_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
`ifdef PARITY_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_par,
    output logic              busy
);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   par_in;
    logic   sr_bit;
    logic   sr_par;
    logic   sr_last;

    assign in_ready = (state == IDLE) || (state == PARITY);
    assign accept   = in_valid && in_ready;

`ifdef PARITY_ERR_INJECT_EN
    assign par_in = even_par(32'(in_data)) ^ err_inject;
`else
    assign par_in = even_par(32'(in_data));
`endif

    parity_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .shift   (state == DATA),
        .data    (in_data),
        .par_in  (par_in),
        .bit_out (sr_bit),
        .par     (sr_par),
        .last    (sr_last)
    );

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and serial outputs, decoded from registered state only.
    always_comb begin
        state_nxt = state;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        ser_par   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                ser_out   = sr_bit;
                ser_valid = 1'b1;
                busy      = 1'b1;
                if (sr_last) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                ser_out   = sr_par;
                ser_valid = 1'b1;
                ser_par   = 1'b1;
                busy      = 1'b1;
                state_nxt = accept ? DATA : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_even_parity_serializer.sv
// Bench for even_parity_serializer (DATA_W = 8). A queue-based frame model
// predicts every serial cycle; literal frame images pin the model.
module tb_even_parity_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         err_inject = 1'b0;
    logic         in_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_par;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Model: queue of {is_parity, bit} entries still to be emitted; head = current cycle.
    logic [1:0] mq[$];
    int         acc_cnt = 0;

    // Captured serial stream.
    logic cap[$];
    logic capp[$];
    int   cur_run = 0;
    int   max_run = 0;

    even_parity_serializer #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef PARITY_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_par   (ser_par),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Frame model: ready when at most the parity bit remains; an accepted word
    // appends its data bits LSB first and a parity bit making the ones count even.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            automatic bit ready_m = (mq.size() <= 1);
            automatic int ones = 0;
            automatic logic p;
            if (mq.size() > 0) void'(mq.pop_front());
            if (in_valid && ready_m) begin
                for (int i = 0; i < W; i++) begin
                    mq.push_back({1'b0, in_data[i]});
                    ones += int'(in_data[i]);
                end
                p = (ones % 2) == 1;
`ifdef PARITY_ERR_INJECT_EN
                if (err_inject) p = ~p;
`endif
                mq.push_back({1'b1, p});
                acc_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic clear_cap();
        cap.delete();
        capp.delete();
        cur_run = 0;
        max_run = 0;
    endtask

    task automatic chk_cap(input string name, input int nbits, input logic [35:0] exp_bits,
                           input logic [35:0] exp_par);
        logic [35:0] gb = '0;
        logic [35:0] gp = '0;
        chk({name, "_len"}, 36'(cap.size()), 36'(nbits));
        for (int i = 0; i < cap.size() && i < 36; i++) begin
            gb[i] = cap[i];
            gp[i] = capp[i];
        end
        chk({name, "_bits"}, gb, exp_bits);
        chk({name, "_parflag"}, gp, exp_par);
    endtask

    task automatic send(input logic [W-1:0] d, input logic e, input bit hold);
        int start;
        int n;
        @(negedge clk);
        in_data    = d;
        in_valid   = 1'b1;
        err_inject = e;
        start      = acc_cnt;
        n          = 0;
        while (acc_cnt == start && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 36'(acc_cnt != start), 36'd1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (mq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 36'(mq.size()), 36'd0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Per-cycle comparison against the model plus stream capture.
        fork
            forever begin
                @(negedge clk);
                begin
                    automatic bit   ev  = (mq.size() > 0);
                    automatic logic eo  = ev ? mq[0][0] : 1'b0;
                    automatic logic ep  = ev ? mq[0][1] : 1'b0;
                    automatic logic er  = (mq.size() <= 1);
                    chk("cycle{valid,out,par,busy,ready}",
                        36'({ser_valid, ser_out, ser_par, busy, in_ready}),
                        36'({ev, eo, ep, ev, er}));
                    if (ser_valid) begin
                        cap.push_back(ser_out);
                        capp.push_back(ser_par);
                        cur_run++;
                        if (cur_run > max_run) max_run = cur_run;
                    end else begin
                        cur_run = 0;
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 36'({ser_out, ser_valid, ser_par, busy}), 36'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready_after_reset", 36'(in_ready), 36'd1);

        // 0xA5: 1,0,1,0,0,1,0,1 then parity 0
        clear_cap();
        send(8'hA5, 1'b0, 1'b0);
        wait_idle();
        chk_cap("frame_a5", 9, 36'h0A5, 36'h100);
        chk("frame_a5_run", 36'(max_run), 36'd9);
        chk("frame_a5_busy_after", 36'(busy), 36'd0);

        // 0x07: 1,1,1,0,0,0,0,0 then parity 1
        clear_cap();
        send(8'h07, 1'b0, 1'b0);
        wait_idle();
        chk_cap("frame_07", 9, 36'h107, 36'h100);

        // Back to back 0x01 then 0xFF with in_valid held high
        clear_cap();
        send(8'h01, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b0);
        wait_idle();
        chk_cap("b2b", 18, {18'h0, 9'h0FF, 9'h101}, {18'h0, 9'h100, 9'h100});
        chk("b2b_run", 36'(max_run), 36'd18);

        // Reset during the 4th data bit of 0x3C
        clear_cap();
        send(8'h3C, 1'b0, 1'b0);
        begin
            int n = 0;
            while (cap.size() < 4 && n < 40) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 36'({ser_valid, ser_par, busy, ser_out}), 36'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", 36'(in_ready), 36'd1);
        repeat (12) @(negedge clk);
        #1;
        chk_cap("abort_partial", 4, 36'hC, 36'h0);
        clear_cap();
        send(8'h00, 1'b0, 1'b0);
        wait_idle();
        chk_cap("frame_00", 9, 36'h000, 36'h100);

        // 0x55 pulsed while 0x96 is in DATA: ignored, frame intact
        clear_cap();
        send(8'h96, 1'b0, 1'b0);
        @(negedge clk);
        in_data  = 8'h55;
        in_valid = 1'b1;
        #1;
        chk("ready_low_in_data", 36'(in_ready), 36'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("ready_low_in_data2", 36'(in_ready), 36'd0);
        in_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        #1;
        chk_cap("frame_96", 9, 36'h096, 36'h100);

`ifdef PARITY_ERR_INJECT_EN
        clear_cap();
        send(8'hA5, 1'b1, 1'b0);
        wait_idle();
        chk_cap("inject_a5", 9, 36'h1A5, 36'h100);
        clear_cap();
        send(8'hA5, 1'b0, 1'b0);
        wait_idle();
        chk_cap("noinject_a5", 9, 36'h0A5, 36'h100);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
